uart_boot_loader: RTL

Receives a program image over the board UART and writes it word-by-word into the SoC instruction/data memory while holding the core in reset. It sits between the board pins and the SoC in each FPGA top: it owns `rx` during boot, drives the memory write port, and generates the core reset. It replaces a fixed power-on delay, so new firmware loads without resynthesis.

---
 rtl/uart_boot_loader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: UART image loader writing program words to memory while holding the core in reset (optional inter-byte timeout via BOOT_TIMEOUT_EN)
module uart_boot_loader #(
    parameter int CLOCK_FREQ     = 27000000,
    parameter int BIT_RATE       = 115200,
    parameter int MEMORY_SIZE    = 2048,
    parameter int TIMEOUT_CYCLES = 2700000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_reset_o,
    output logic        boot_done,
    output logic        error
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BIT_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [15:0] MAX_LEN = 16'(MEMORY_SIZE);
    localparam logic [7:0] SYNC = 8'hB5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {L_IDLE, L_LEN_LO, L_LEN_HI, L_DATA, L_CSUM, L_DONE} ld_state_t;

    rx_state_t r_rx_state, w_rx_next;
    ld_state_t r_ld_state, w_ld_next;
    logic r_rx_s1, r_rx_s2;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0] r_rx_bit;
    logic [7:0] r_rx_shift;
    logic r_byte_valid, r_frame_err;
    logic [15:0] r_len, r_idx;
    logic [1:0] r_bcnt;
    logic [23:0] r_word;
    logic [7:0] r_xor;
    logic r_mem_we, r_core_rst, r_done, r_error;
    logic [31:0] r_mem_addr, r_mem_wdata;
    logic w_tick_half, w_tick_full, w_sync, w_bad_len, w_busy, w_timeout, w_abort, w_last;
    logic [15:0] w_len;

    assign w_tick_half = r_rx_cnt == HALF;
    assign w_tick_full = r_rx_cnt == FULL;
    assign w_sync = r_byte_valid && r_rx_shift == SYNC;
    assign w_len = {r_rx_shift, r_len[7:0]};
    assign w_bad_len = w_len == 16'd0 || w_len > MAX_LEN;
    assign w_busy = r_ld_state != L_IDLE && r_ld_state != L_DONE;
    assign w_abort = w_busy && (r_frame_err || w_timeout);
    assign w_last = r_bcnt == 2'd3 && r_idx + 16'd1 == r_len;

    assign mem_we = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign core_reset_o = r_core_rst;
    assign boot_done = r_done;
    assign error = r_error;

`ifdef BOOT_TIMEOUT_EN
    localparam logic [31:0] TO = 32'(TIMEOUT_CYCLES);
    logic [31:0] r_to_cnt;
    // saturating inter-byte watchdog, running only while a load is in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_to_cnt <= '0;
        else
            r_to_cnt <= (r_byte_valid || !w_busy) ? '0 : (r_to_cnt == TO ? r_to_cnt : r_to_cnt + 32'd1);
    end
    assign w_timeout = r_to_cnt == TO;
`else
    assign w_timeout = TIMEOUT_CYCLES < 0;
`endif

    // two-flop synchronizer for the asynchronous rx pin
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
        end
    end

    // receiver next state: start check at half bit, data and stop at mid-bit
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  w_rx_next = r_rx_s2 ? RX_IDLE : RX_START;
            RX_START: if (w_tick_half) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_tick_full && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
            RX_STOP:  if (w_tick_full) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    // receiver state, bit timer, data shift and byte/framing-error pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_next;
            r_byte_valid <= r_rx_state == RX_STOP && w_tick_full && r_rx_s2;
            r_frame_err  <= r_rx_state == RX_STOP && w_tick_full && !r_rx_s2;
            r_rx_cnt     <= (r_rx_state == RX_IDLE || w_rx_next != r_rx_state || w_tick_full) ? '0 : r_rx_cnt + 1'b1;
            if (r_rx_state == RX_DATA && w_tick_full) begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
        end
    end

    // loader next state; framing errors and timeouts during a load abort to IDLE
    always_comb begin
        w_ld_next = r_ld_state;
        case (r_ld_state)
            L_IDLE, L_DONE: if (w_sync) w_ld_next = L_LEN_LO;
            L_LEN_LO:       if (r_byte_valid) w_ld_next = L_LEN_HI;
            L_LEN_HI:       if (r_byte_valid) w_ld_next = w_bad_len ? L_IDLE : L_DATA;
            L_DATA:         if (r_byte_valid && w_last) w_ld_next = L_CSUM;
            L_CSUM:         if (r_byte_valid) w_ld_next = r_rx_shift == r_xor ? L_DONE : L_IDLE;
            default:        w_ld_next = L_IDLE;
        endcase
        if (w_abort)
            w_ld_next = L_IDLE;
    end

    // loader datapath: length capture, word assembly, memory writes, checksum and flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ld_state  <= L_IDLE;
            r_len       <= '0;
            r_idx       <= '0;
            r_bcnt      <= '0;
            r_word      <= '0;
            r_xor       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_core_rst  <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_ld_state <= w_ld_next;
            r_mem_we   <= 1'b0;
            if (r_frame_err || w_abort)
                r_error <= 1'b1;
            if (r_byte_valid && !w_abort) begin
                case (r_ld_state)
                    L_IDLE, L_DONE: if (w_sync) begin
                        r_error    <= 1'b0;
                        r_done     <= 1'b0;
                        r_idx      <= '0;
                        r_xor      <= '0;
                        r_bcnt     <= '0;
                        r_core_rst <= 1'b1;
                    end
                    L_LEN_LO: r_len[7:0] <= r_rx_shift;
                    L_LEN_HI: begin
                        r_len[15:8] <= r_rx_shift;
                        if (w_bad_len)
                            r_error <= 1'b1;
                    end
                    L_DATA: begin
                        r_xor  <= r_xor ^ r_rx_shift;
                        r_word <= {r_rx_shift, r_word[23:8]};
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {14'd0, r_idx, 2'b00};
                            r_mem_wdata <= {r_rx_shift, r_word};
                            r_idx       <= r_idx + 16'd1;
                        end
                    end
                    L_CSUM: if (r_rx_shift == r_xor) begin
                        r_done     <= 1'b1;
                        r_core_rst <= 1'b0;
                    end else
                        r_error <= 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule
